seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Generic multiplexed 7-segment scanner for the digital-clock front panel: N-digit time-multiplexed
//  drive with per-digit hex decode, decimal point, blanking and blink (edit-cursor flash).
//  Sits between the time/keyboard-edit logic (BCD/hex nibbles + masks) and board segment pins.
//  Single clock domain; replaces divided-clock scanners with clock-enable ticks.
// PARAMETERS
//  NUM_DIGITS   8            physical digits driven (1..8)
//  CLK_HZ       100_000_000  input clock frequency
//  SCAN_HZ      1_000        digit-advance rate (one digit per tick)
//  BLINK_HZ     2            blink period rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
//  GUARD_CYC    4            all-digits-off cycles inserted at each digit change (anti-ghosting)
//  ACTIVE_LOW   1            1: seg_en/seg_out active-low (board default); 0: active-high
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous, active-high reset
//  en           in   1             0: all digits dark (scan keeps running)
//  active_cnt   in   4             digits scanned, index 0..active_cnt-1; 0 -> 1, >NUM_DIGITS -> NUM_DIGITS
//  digits       in   4*NUM_DIGITS  nibble per digit, digit i = digits[4i+3:4i], digit 0 rightmost
//  dp_mask      in   NUM_DIGITS    1: light DP of digit i
//  blank_mask   in   NUM_DIGITS    1: digit i always dark
//  blink_mask   in   NUM_DIGITS    1: digit i dark during blink-off phase
//  seg_en       out  NUM_DIGITS    digit enables, one-hot (or none) in active polarity
//  seg_out      out  8             {dp,g,f,e,d,c,b,a} in active polarity
//  scan_tick    out  1             1-cycle pulse on each digit advance
// BEHAVIOUR
//  - Reset: prescaler=0, idx=0, guard=0, blink_phase=1 (visible); seg_en all inactive,
//    seg_out all off, scan_tick=0. All outputs registered.
//  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1; scan_tick=1 in the cycle it wraps.
//  - On tick: idx <= (idx+1 >= eff_cnt) ? 0 : idx+1 (eff_cnt = clamped active_cnt);
//    covers active_cnt shrinking below idx (wraps to 0 on next tick, never out of range).
//  - Guard: on tick, guard counter loads GUARD_CYC; while guard!=0 seg_en all inactive, seg_out off.
//    GUARD_CYC=0 disables. Guard must be < CLK_HZ/SCAN_HZ (elaboration check).
//  - Output cycle: seg_en/seg_out reflect idx one cycle after idx updates (1-cycle registered latency);
//    with guard, digit lights GUARD_CYC+1 cycles after tick.
//  - Digit lit iff en & ~blank_mask[idx] & ~(blink_mask[idx] & ~blink_phase); else seg_en inactive.
//  - Decode: full hex 0-F (A b C d E F); dp from dp_mask[idx]. Polarity via ACTIVE_LOW XOR at output.
//  - Blink counter free-runs independently of scan; inputs sampled live (no latching), so mask/digit
//    changes take effect on next output register update.
//  - rst mid-scan: returns to reset state next edge regardless of guard/prescaler state.
// STRUCTURE
//  - Shared package: 7-seg pattern constants SEG_0..SEG_F, SEG_OFF, function clog2, width localparams.
//  - One sub-module: seg7_hex_decode (4-bit nibble -> 7-bit active-high pattern, combinational).
//  - Top: prescaler, blink divider, idx counter, guard counter, output register.
// TESTING (CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 cycles; BLINK_HZ=50 -> phase toggles every 10; GUARD_CYC=2)
//  1. rst held 3 cycles -> seg_en=8'hFF, seg_out=8'hFF, scan_tick=0; release -> first tick at cycle 10.
//  2. active_cnt=6, digits=32'h00_123456, en=1 -> idx sequence 0..5,0; digit0 seg_out=8'h82 ('6'),
//     seg_en=8'hFE, lit 3 cycles after tick; seg_en=8'hFF for 2 guard cycles.
//  3. active_cnt 6 -> 4 while idx=5 -> next tick idx=0; thereafter 0..3 only; active_cnt=0 -> idx stays 0.
//  4. blink_mask=8'h04, digit2 -> dark whenever blink_phase=0, lit otherwise; others unaffected.
//  5. dp_mask=8'h10, digits nibble4=4'hA -> on idx4 seg_out=8'h08 ('A' + DP); blank_mask=8'h10 -> seg_en=8'hFF.
//  6. en=0 -> seg_en=8'hFF always, scan_tick continues; ACTIVE_LOW=0 build -> all outputs inverted.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment patterns
// (bit order {g,f,e,d,c,b,a}, active-high), port widths and a ceil-log2 helper.
package seg7_scan_display_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 7;
  localparam int CNT_W = 4;
  localparam int OUT_W = 8;

  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F   = 7'h71;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder (active-high, no DP).
module seg7_hex_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] pattern
);

  // Full hex table, lower-case b and d so they differ from 8 and 0
  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      4'hF:    pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with clock-enable scan ticks,
// anti-ghosting guard gap, blanking, blink and output polarity select.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD_CYC  = 4,
  parameter bit ACTIVE_LOW = 1'b1
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CNT_W-1:0]            active_cnt,
  input  logic [NIB_W*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [NUM_DIGITS-1:0]       seg_en,
  output logic [OUT_W-1:0]            seg_out,
  output logic                        scan_tick
);

  localparam int PRE_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = (PRE_DIV > 1) ? clog2(PRE_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? clog2(BLINK_DIV) : 1;
  localparam int GUARD_W   = (GUARD_CYC > 0) ? clog2(GUARD_CYC + 1) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_MAX    = PRE_W'(PRE_DIV - 1);
  localparam logic [BLINK_W-1:0]    BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [GUARD_W-1:0]    GUARD_LOAD = GUARD_W'(GUARD_CYC);
  localparam logic [CNT_W:0]        ND_MAX     = (CNT_W + 1)'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] EN_POL     = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [OUT_W-1:0]      SEG_POL    = {OUT_W{ACTIVE_LOW}};

  if (GUARD_CYC >= PRE_DIV) begin : g_guard_too_long
    $error("GUARD_CYC must be smaller than CLK_HZ/SCAN_HZ");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 1..8");
  end

  logic [PRE_W-1:0]      pre_cnt_r;
  logic [BLINK_W-1:0]    blink_cnt_r;
  logic                  blink_phase_r;
  logic [IDX_W-1:0]      idx_r;
  logic [GUARD_W-1:0]    guard_r;
  logic                  tick_s;
  logic [CNT_W:0]        eff_cnt_s;
  logic [CNT_W:0]        idx_inc_s;
  logic [IDX_W-1:0]      idx_next_s;
  logic [NIB_W-1:0]      nibble_s;
  logic [SEG_W-1:0]      pattern_s;
  logic                  lit_s;
  logic [NUM_DIGITS-1:0] seg_en_s;
  logic [OUT_W-1:0]      seg_out_s;

  assign tick_s   = (pre_cnt_r == PRE_MAX);
  assign nibble_s = digits[{idx_r, 2'b00} +: NIB_W];

  seg7_hex_decode u_decode (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // Scan prescaler; scan_tick marks the cycle in which it wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= tick_s;
      if (tick_s) begin
        pre_cnt_r <= {PRE_W{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
    end
  end

  // Free-running blink divider, phase starts in the visible half
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= 1'b1;
    end else if (blink_cnt_r == BLINK_MAX) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
      blink_phase_r <= blink_phase_r;
    end
  end

  // Next digit index; a shrunk active_cnt simply wraps to 0 at the next tick
  always_comb begin
    eff_cnt_s  = {1'b0, active_cnt};
    idx_next_s = {IDX_W{1'b0}};
    if (active_cnt == 4'd0) begin
      eff_cnt_s = 5'd1;
    end else if ({1'b0, active_cnt} > ND_MAX) begin
      eff_cnt_s = ND_MAX;
    end else begin
      eff_cnt_s = {1'b0, active_cnt};
    end
    idx_inc_s = (CNT_W + 1)'(idx_r) + 5'd1;
    if (idx_inc_s >= eff_cnt_s) begin
      idx_next_s = {IDX_W{1'b0}};
    end else begin
      idx_next_s = idx_inc_s[IDX_W-1:0];
    end
  end

  // Digit index and guard gap both restart on every scan tick
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {IDX_W{1'b0}};
      guard_r <= {GUARD_W{1'b0}};
    end else if (tick_s) begin
      idx_r   <= idx_next_s;
      guard_r <= GUARD_LOAD;
    end else if (guard_r != {GUARD_W{1'b0}}) begin
      guard_r <= guard_r - GUARD_W'(1);
    end else begin
      guard_r <= guard_r;
    end
  end

  always_comb begin
    seg_en_s  = {NUM_DIGITS{1'b0}};
    seg_out_s = {OUT_W{1'b0}};
    lit_s = en & ~blank_mask[idx_r] & ~(blink_mask[idx_r] & ~blink_phase_r)
            & (guard_r == {GUARD_W{1'b0}});
    if (lit_s) begin
      seg_en_s  = DIGIT0 << idx_r;
      seg_out_s = {dp_mask[idx_r], pattern_s};
    end else begin
      seg_en_s  = {NUM_DIGITS{1'b0}};
      seg_out_s = {OUT_W{1'b0}};
    end
  end

  // Output register; polarity applied as a constant XOR so reset reads "all off"
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en  <= EN_POL;
      seg_out <= SEG_POL;
    end else begin
      seg_en  <= seg_en_s ^ EN_POL;
      seg_out <= seg_out_s ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: edge-counting reference model plus directed pins,
// run against an active-low and an active-high build side by side.
module tb_seg7_scan_display;

  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int BLINK_HZ = 50;
  localparam int GUARD    = 2;
  localparam int TICK     = CLK_HZ / SCAN_HZ;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  active_cnt;
  logic [31:0] digits;
  logic [7:0]  dp_mask, blank_mask, blink_mask;
  logic [7:0]  lo_en, lo_out, hi_en, hi_out;
  logic        lo_tick, hi_tick;

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(8), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ),
                      .GUARD_CYC(GUARD), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .active_cnt(active_cnt), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg_en(lo_en), .seg_out(lo_out), .scan_tick(lo_tick));

  seg7_scan_display #(.NUM_DIGITS(8), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ),
                      .GUARD_CYC(GUARD), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(en), .active_cnt(active_cnt), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg_en(hi_en), .seg_out(hi_out), .scan_tick(hi_tick));

  int checks = 0;
  int passes = 0;
  bit run    = 1'b0;
  int e      = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Lit segments per hex digit, spelled out by segment letter
  string SEGS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] pat(input logic [3:0] v);
    logic [6:0] r;
    string s;
    r = 7'd0;
    s = SEGS[v];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic int eff(input logic [3:0] c);
    if (c == 4'd0) return 1;
    if (c > 4'd8) return 8;
    return int'(c);
  endfunction

  // Reference model: n = clock edges since reset release
  int n = 0, mi = 0, last_tick = -1000;
  bit guard_dark, vis, lit;
  logic [7:0] exp_en = 8'hFF, exp_out = 8'hFF;
  logic       exp_tick = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; mi = 0; last_tick = -1000;
      exp_en = 8'hFF; exp_out = 8'hFF; exp_tick = 1'b0;
    end else begin
      n++;
      guard_dark = (n - last_tick >= 1) && (n - last_tick <= GUARD);
      vis = (((n - 1) / HALF) % 2) == 0;
      lit = en && !blank_mask[mi] && !(blink_mask[mi] && !vis) && !guard_dark;
      exp_en  = lit ? ~(8'd1 << mi) : 8'hFF;
      exp_out = lit ? ~{dp_mask[mi], pat(digits[mi*4 +: 4])} : 8'hFF;
      exp_tick = (n % TICK) == 0;
      if (exp_tick) begin
        last_tick = n;
        mi = (mi + 1 >= eff(active_cnt)) ? 0 : mi + 1;
      end
    end
  end

  // Every-cycle comparison of both builds against the model
  always @(negedge clk) begin
    if (run) begin
      check("lo_seg_en",  lo_en,  exp_en);
      check("lo_seg_out", lo_out, exp_out);
      check("lo_tick",    {7'd0, lo_tick}, {7'd0, exp_tick});
      check("hi_seg_en",  hi_en,  ~exp_en);
      check("hi_seg_out", hi_out, ~exp_out);
      check("hi_tick",    {7'd0, hi_tick}, {7'd0, exp_tick});
    end
  end

  task automatic go_to(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic pin(input string name, input logic [7:0] en_req, input logic [7:0] out_req);
    check({name, "_en"},  lo_en,  en_req);
    check({name, "_out"}, lo_out, out_req);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; active_cnt = 4'd0; digits = 32'h0;
    dp_mask = 8'h00; blank_mask = 8'h00; blink_mask = 8'h00;
    run = 1'b1;
    repeat (3) @(negedge clk);
    pin("reset", 8'hFF, 8'hFF);
    check("reset_tick", {7'd0, lo_tick}, 8'h00);
    rst = 1'b0; en = 1'b1; active_cnt = 4'd6; digits = 32'h0012_3456;

    go_to(5);   pin("digit0_six", 8'hFE, 8'h82);
    go_to(9);   check("tick_before", {7'd0, lo_tick}, 8'h00);
    go_to(10);  check("first_tick", {7'd0, lo_tick}, 8'h01);
    go_to(11);  pin("guard", 8'hFF, 8'hFF);
    go_to(13);  pin("digit1_five", 8'hFD, 8'h92);
    go_to(63);  pin("wrap_digit0", 8'hFE, 8'h82);

    go_to(115); active_cnt = 4'd4;
    go_to(123); pin("shrink_wrap", 8'hFE, 8'h82);
    go_to(163); pin("cnt4_wrap", 8'hFE, 8'h82);
    go_to(165); active_cnt = 4'd0;
    go_to(173); pin("cnt0_a", 8'hFE, 8'h82);
    go_to(183); pin("cnt0_b", 8'hFE, 8'h82);

    go_to(185); active_cnt = 4'd3; digits = 32'h7654_3210; blink_mask = 8'h04;
    go_to(205); pin("blink_on", 8'hFB, 8'hA4);
    go_to(215); pin("blink_other", 8'hFE, 8'hC0);
    go_to(235); pin("blink_off", 8'hFF, 8'hFF);

    go_to(245); active_cnt = 4'd5; blink_mask = 8'h00; dp_mask = 8'h10; digits = 32'h000A_0000;
    go_to(285); pin("a_with_dp", 8'hEF, 8'h08);
    blank_mask = 8'h10;
    go_to(288); pin("blanked", 8'hFF, 8'hFF);

    go_to(295); blank_mask = 8'h00; en = 1'b0;
    go_to(300); check("tick_when_off", {7'd0, lo_tick}, 8'h01);
    go_to(305); pin("en_off", 8'hFF, 8'hFF);
    go_to(315); en = 1'b1;
    go_to(321); rst = 1'b1;
    go_to(322); pin("mid_reset", 8'hFF, 8'hFF);
    check("mid_reset_tick", {7'd0, lo_tick}, 8'h00);
    go_to(324); rst = 1'b0;
    go_to(333); check("retick_before", {7'd0, lo_tick}, 8'h00);
    go_to(334); check("retick", {7'd0, lo_tick}, 8'h01);
    go_to(340);
    run = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
